// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player: state encoding, note word layout, step table.
package note_player_pkg;

    localparam int unsigned NOTE_W   = 6;
    localparam int unsigned DUR_W    = 6;
    localparam int unsigned STEP_W   = 20;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NOTE_LSB = 10;
    localparam int unsigned DUR_LSB  = 4;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Equal-tempered steps: one 12-entry base octave, doubled per octave above note 1.
    function automatic logic [STEP_W-1:0] step_lookup(input logic [NOTE_W-1:0] note);
        logic [NOTE_W-1:0] idx;
        logic [2:0]        oct;
        logic [3:0]        semi;
        logic [STEP_W-1:0] base;
        logic [STEP_W-1:0] result;
        idx  = note - NOTE_W'(1);
        oct  = 3'(idx / NOTE_W'(12));
        semi = 4'(idx % NOTE_W'(12));
        case (semi)
            4'd0:    base = STEP_W'(1000);
            4'd1:    base = STEP_W'(1059);
            4'd2:    base = STEP_W'(1122);
            4'd3:    base = STEP_W'(1189);
            4'd4:    base = STEP_W'(1260);
            4'd5:    base = STEP_W'(1335);
            4'd6:    base = STEP_W'(1414);
            4'd7:    base = STEP_W'(1498);
            4'd8:    base = STEP_W'(1587);
            4'd9:    base = STEP_W'(1682);
            4'd10:   base = STEP_W'(1782);
            4'd11:   base = STEP_W'(1888);
            default: base = '0;
        endcase
        if (note == REST_NOTE) begin
            result = '0;
        end else begin
            result = base << oct;
        end
        return result;
    endfunction

endpackage

// File: rtl/note_player_frequency_rom.sv
// Synchronous step-size ROM, one cycle latency; output forced to 0 when not enabled.
module frequency_rom
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] data
);

    logic [STEP_W-1:0] data_d;
    logic [STEP_W-1:0] data_q;

    always_comb begin
        data_d = '0;
        if (en) begin
            data_d = step_lookup(addr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/note_player.sv
// Holds one note from the sequencer for its duration in beats and drives the tone step size.
module note_player
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic              beat,
    input  logic              new_note,
    input  logic [DATA_W-1:0] note_data,
    output logic              note_done,
    output logic [NOTE_W-1:0] note_out,
    output logic [STEP_W-1:0] step_size,
    output logic              busy,
    output logic              load_new_note
);

    state_e            state_q, state_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              busy_q, busy_d;
    logic              load_q, load_d;
    logic              done_q, done_d;

    logic [NOTE_W-1:0] in_note;
    logic [DUR_W-1:0]  in_dur;
    logic              unused_rsvd;

    assign in_note     = note_data[NOTE_LSB +: NOTE_W];
    assign in_dur      = note_data[DUR_LSB +: DUR_W];
    assign unused_rsvd = ^note_data[DUR_LSB-1:0];

    // Done is raised on entering FINISH from PLAY, or on leaving it when a zero-length note skipped PLAY.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        note_d  = note_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_note) begin
                    note_d  = in_note;
                    rem_d   = in_dur;
                    load_d  = 1'b1;
                    state_d = (in_dur == '0) ? ST_FINISH : ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (beat && play_enable && (rem_q != '0)) begin
                    rem_d = rem_q - DUR_W'(1);
                    if (rem_q == DUR_W'(1)) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                note_d  = REST_NOTE;
                done_d  = !done_q;
            end
            default: begin
                state_d = ST_IDLE;
                note_d  = REST_NOTE;
                rem_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            note_q  <= REST_NOTE;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            note_q  <= note_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

    // Gate on the next busy value so the step drops to 0 as the player returns to IDLE.
    frequency_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .en    (play_enable && busy_d),
        .addr  (note_q),
        .data  (step_size)
    );

    assign note_done     = done_q;
    assign note_out      = note_q;
    assign busy          = busy_q;
    assign load_new_note = load_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed scenarios then random traffic against a beat-count model.
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic        beat;
    logic        new_note;
    logic [15:0] note_data;
    logic        note_done;
    logic [5:0]  note_out;
    logic [19:0] step_size;
    logic        busy;
    logic        load_new_note;

    int total = 0;
    int bad   = 0;

    // Reference state: is a note held, beats still owed, which note, and whether it was zero-length.
    bit          m_busy = 1'b0;
    bit          m_zero = 1'b0;
    int          m_left = 0;
    int          m_note = 0;
    logic        e_done = 1'b0;
    logic        e_load = 1'b0;
    logic [19:0] e_step = '0;

    always #5 clk = ~clk;

    note_player dut (
        .clk           (clk),
        .reset         (reset),
        .play_enable   (play_enable),
        .beat          (beat),
        .new_note      (new_note),
        .note_data     (note_data),
        .note_done     (note_done),
        .note_out      (note_out),
        .step_size     (step_size),
        .busy          (busy),
        .load_new_note (load_new_note)
    );

    // Equal temperament from a 1000-unit base at note 1, doubling every 12 notes.
    function automatic logic [19:0] ref_step(input int n);
        real r;
        if (n == 0) return 20'd0;
        r = 1000.0;
        for (int s = 0; s < (n - 1) % 12; s++) r = r * 1.0594630943592953;
        return 20'(int'(r)) << ((n - 1) / 12);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_zero = 1'b0;
        m_left = 0;
        m_note = 0;
        e_done = 1'b0;
        e_load = 1'b0;
        e_step = '0;
    endtask

    task automatic model_edge();
        int old_note;
        old_note = m_note;
        e_done   = 1'b0;
        e_load   = 1'b0;
        if (!reset) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (new_note) begin
                m_note = int'(note_data[15:10]);
                m_left = int'(note_data[9:4]);
                m_zero = (m_left == 0);
                m_busy = 1'b1;
                e_load = 1'b1;
            end
        end else if (m_zero || m_left == 0) begin
            if (m_zero) e_done = 1'b1;
            m_busy = 1'b0;
            m_zero = 1'b0;
            m_note = 0;
        end else if (beat && play_enable) begin
            m_left = m_left - 1;
            if (m_left == 0) e_done = 1'b1;
        end
        e_step = (play_enable && m_busy) ? ref_step(old_note) : 20'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("note_done", 32'(note_done), 32'(e_done));
        chk("load_new_note", 32'(load_new_note), 32'(e_load));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("note_out", 32'(note_out), 32'(m_note));
        chk("step_size", 32'(step_size), 32'(e_step));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cyc(input logic nn, input logic [15:0] d, input logic bt, input logic pe);
        new_note    = nn;
        note_data   = d;
        beat        = bt;
        play_enable = pe;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset       = 1'b0;
        play_enable = 1'b1;
        beat        = 1'b0;
        new_note    = 1'b0;
        note_data   = '0;
        #1;
        chk("reset_note_done", 32'(note_done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_step", 32'(step_size), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0C30, 1'b1, 1'b1);
        reset = 1'b1;

        // note 3, duration 3, beat every 10 cycles
        cyc(1'b1, 16'h0C30, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, 16'h0000, (i % 10) == 9, 1'b1);

        // duration 0 finishes without beats
        cyc(1'b1, 16'h0C00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b1);

        // rest of duration 2
        cyc(1'b1, 16'h0020, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0, 16'h0000, (i % 10) == 9, 1'b1);

        // note 5, duration 4, paused across five beats after the first
        cyc(1'b1, 16'h1440, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, 16'h0000, (i % 4) == 3, !(i >= 4 && i < 24));

        // second new_note while playing is ignored
        cyc(1'b1, 16'h0C30, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(i == 5, 16'hFFF0, (i % 10) == 9, 1'b1);

        // reset in the middle of note 10, duration 5
        cyc(1'b1, 16'h2850, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 16'h0000, (i % 10) == 9, 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("midreset_note_done", 32'(note_done), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_note_out", 32'(note_out), 32'd0);
        chk("midreset_step", 32'(step_size), 32'd0);
        chk("midreset_load", 32'(load_new_note), 32'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b1);
        reset = 1'b1;
        cyc(1'b1, 16'hFC30, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, 16'h0000, (i % 10) == 9, 1'b1);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 400) != 0;
            cyc(($urandom % 8) == 0, 16'($urandom), ($urandom % 3) == 0, ($urandom % 6) != 0);
        end
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_player.md
# note_player

Downstream consumer of the song sequencer's note stream. Accepts one 16-bit note word per `new_note` strobe, holds the note for its encoded duration counted in beat ticks, drives a frequency step size to the tone generator, and returns a one-cycle `note_done` so the sequencer fetches the next entry. Pausing is supported via `play_enable`; a rest is encoded as note 0.

## Interface
- `NOTE_W`, 6: note-number field width.
- `DUR_W`, 6: duration field width, in beats.
- `STEP_W`, 20: step-size output width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `play_enable`  in  1  1 = play; 0 = pause (beats ignored, output silenced).
- `beat`  in  1  one-cycle tick, 48 per second; unit of duration.
- `new_note`  in  1  one-cycle strobe; `note_data` valid in the same cycle.
- `note_data`  in  16  bits [15:10] note, [9:4] duration, [3:0] reserved (ignored).
- `note_done`  out  1  one-cycle pulse when the current note's duration expires.
- `note_out`  out  6  note currently held; 0 when idle.
- `step_size`  out  20  phase increment for the tone generator; 0 for rest, idle, or pause.
- `busy`  out  1  1 while a note is held (state PLAY or FINISH).
- `load_new_note`  out  1  one-cycle pulse: a note was accepted; tone generator resets phase.

## Operation
- States: IDLE, PLAY, FINISH.
- IDLE: `new_note`=1 latches note and duration; next state PLAY. Duration 0 goes to FINISH instead.
- PLAY: `beat`=1 with `play_enable`=1 decrements the remaining count. When a beat takes remaining from 1 to 0, next state is FINISH.
- FINISH: `note_done`=1 for exactly this cycle, then IDLE. `note_out` clears to 0 on entering IDLE.
- `new_note` in PLAY or FINISH is ignored; held note and count are unchanged.
- `beat` in IDLE or FINISH is ignored. A `beat` coincident with acceptance of a note is not counted.
- `play_enable`=0: remaining count frozen, state held, `step_size` forced to 0, `note_out` held. FINISH still completes if already entered.
- `step_size` is the table lookup of `note_out`, gated by `play_enable` and `busy`. Note 0 maps to 0. Notes 1–63 map to the equal-tempered step table; the table contents are generated offline.
- Duration counter is `DUR_W` bits, unsigned, and counts down only. It never wraps below 0.

## Timing
- Reset values: state IDLE; `note_done`, `load_new_note`, `busy` all 0; `note_out` 0; `step_size` 0; remaining count 0.
- `reset` asserted mid-note aborts immediately with no `note_done`. The first edge after release samples inputs normally.
- `new_note` accepted at edge N gives `note_out`, `busy` and `load_new_note` at cycle N+1. `step_size` is valid at N+2 because the ROM is synchronous with one cycle of latency.
- Duration D ≥ 1: `note_done` is high in the cycle after the D-th counted beat. `busy` falls together with `note_done` going low.
- Duration 0: `note_done` at cycle N+2, with no beat required.
- The sequencer sees `note_done` and issues the next `new_note` at the earliest 2 cycles later. The player is already IDLE in that cycle, so back-to-back notes are never dropped.
- `load_new_note` and `note_done` are registered outputs with no combinational path from any input.

## Structure
- Shared package holds: the state encoding (IDLE=2'd0, PLAY=2'd1, FINISH=2'd2), the field positions of `note_data`, `NOTE_W`/`DUR_W`/`STEP_W`, and `REST_NOTE`=0.
- Sub-module `frequency_rom`: synchronous ROM with 64 entries of `STEP_W` bits, addressed by `note_out`. Entry 0 is 0.
- State and count are held in the team's resettable flop cells, with reset polarity adapted to active-low.

## Test plan
- Note word 16'h0C30 (note 3, duration 3) in IDLE, `beat` every 10 cycles → `load_new_note` at N+1; `note_done` one cycle after the 3rd beat; `note_out`=3 throughout, then 0.
- Duration 0 (16'h0C00) → no beat needed; `note_done` at N+2; `busy` high for exactly 1 cycle.
- Rest (16'h0020, duration 2) → `step_size` stays 0 throughout; `note_done` after the 2nd beat.
- Pause: `play_enable`=0 after the 1st of 4 beats for 5 beats, then 1 → paused beats not counted; `step_size`=0 while paused; `note_done` after 3 further counted beats.
- `new_note` with 16'hFFF0 during PLAY → ignored; original `note_out` and `note_done` timing are unchanged.
- `reset`=0 at the midpoint of a note → all outputs 0 immediately; no `note_done`; a fresh note after release plays normally.
